// File: rtl/mac_array_ctrl.sv
// mac_array_ctrl: job sequencer for the mac_array systolic datapath.
// Accepts a job (start_i/k_len_i), clears the array for one cycle, streams
// K operand beats from an upstream valid/ready source onto the array feed
// ports, waits DRAIN_CYCLES for the systolic drain, then holds res_valid_o
// until res_ready_i.
// Ports:
//   clk_i, rst_i                 clock, async active-high reset
//   start_i, k_len_i, abort_i    job control
//   a_data_i, b_data_i           upstream operand vectors
//   op_valid_i / op_ready_o      upstream beat handshake
//   array_a_o, array_b_o         registered operand feed to the array
//   feed_a_valid_o, feed_b_valid_o  registered feed valids
//   a_clr_o, b_clr_o, acc_clr_o  array clears (asserted in CLEAR)
//   res_valid_o / res_ready_i    result handshake
//   busy_o, done_o               status, done_o is a one-cycle pulse
module mac_array_ctrl #(
   parameter int unsigned DATA_WIDTH   = 16,
   parameter int unsigned M_ROWS       = 5,
   parameter int unsigned N_COLS       = M_ROWS,
   parameter int unsigned K_WIDTH      = 8,
   parameter int unsigned DRAIN_CYCLES = M_ROWS + N_COLS
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         start_i,
   input  logic [K_WIDTH-1:0]           k_len_i,
   input  logic                         abort_i,
   input  logic [M_ROWS*DATA_WIDTH-1:0] a_data_i,
   input  logic [N_COLS*DATA_WIDTH-1:0] b_data_i,
   input  logic                         op_valid_i,
   output logic                         op_ready_o,
   output logic [M_ROWS*DATA_WIDTH-1:0] array_a_o,
   output logic [N_COLS*DATA_WIDTH-1:0] array_b_o,
   output logic                         feed_a_valid_o,
   output logic                         feed_b_valid_o,
   output logic                         a_clr_o,
   output logic                         b_clr_o,
   output logic                         acc_clr_o,
   output logic                         res_valid_o,
   input  logic                         res_ready_i,
   output logic                         busy_o,
   output logic                         done_o
);

   localparam int unsigned A_W = M_ROWS * DATA_WIDTH;
   localparam int unsigned B_W = N_COLS * DATA_WIDTH;
   localparam int unsigned D_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_CLEAR  = 3'd1;
   localparam logic [2:0] S_FEED   = 3'd2;
   localparam logic [2:0] S_DRAIN  = 3'd3;
   localparam logic [2:0] S_RESULT = 3'd4;

   logic [2:0]         state_q, state_d;
   logic [K_WIDTH-1:0] k_len_q, k_len_d;
   logic [K_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
   logic [D_W-1:0]     drain_cnt_q, drain_cnt_d;
   logic [A_W-1:0]     a_q, a_d;
   logic [B_W-1:0]     b_q, b_d;
   logic               fv_q, fv_d;
   logic               done_q, done_d;
   logic               accept;

   // Moore decode; ready is additionally gated so an aborting cycle takes no beat
   assign op_ready_o  = (state_q == S_FEED) && !abort_i;
   assign a_clr_o     = (state_q == S_CLEAR);
   assign b_clr_o     = (state_q == S_CLEAR);
   assign acc_clr_o   = (state_q == S_CLEAR);
   assign res_valid_o = (state_q == S_RESULT);
   assign busy_o      = (state_q != S_IDLE);
   assign accept      = op_ready_o && op_valid_i;

   assign array_a_o      = a_q;
   assign array_b_o      = b_q;
   assign feed_a_valid_o = fv_q;
   assign feed_b_valid_o = fv_q;
   assign done_o         = done_q;

   // State and datapath registers
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= S_IDLE;
         k_len_q     <= '0;
         beat_cnt_q  <= '0;
         drain_cnt_q <= '0;
         a_q         <= '0;
         b_q         <= '0;
         fv_q        <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         k_len_q     <= k_len_d;
         beat_cnt_q  <= beat_cnt_d;
         drain_cnt_q <= drain_cnt_d;
         a_q         <= a_d;
         b_q         <= b_d;
         fv_q        <= fv_d;
         done_q      <= done_d;
      end
   end

   // Next-state and registered-output logic
   always_comb begin
      state_d     = state_q;
      k_len_d     = k_len_q;
      beat_cnt_d  = beat_cnt_q;
      drain_cnt_d = drain_cnt_q;
      a_d         = '0;
      b_d         = '0;
      fv_d        = 1'b0;
      done_d      = 1'b0;

      case (state_q)
         S_IDLE: begin
            // abort wins over a coincident start
            if (start_i && (k_len_i != '0) && !abort_i) begin
               k_len_d    = k_len_i;
               beat_cnt_d = '0;
               state_d    = S_CLEAR;
            end
         end
         S_CLEAR: begin
            state_d = S_FEED;
         end
         S_FEED: begin
            if (accept) begin
               a_d        = a_data_i;
               b_d        = b_data_i;
               fv_d       = 1'b1;
               beat_cnt_d = K_WIDTH'(beat_cnt_q + K_WIDTH'(1));
               // compare against k-1 so a 2^K-1 beat job never wraps the counter
               if (beat_cnt_q == K_WIDTH'(k_len_q - K_WIDTH'(1))) begin
                  beat_cnt_d  = '0;
                  drain_cnt_d = '0;
                  state_d     = S_DRAIN;
               end
            end
         end
         S_DRAIN: begin
            if (drain_cnt_q == D_W'(DRAIN_CYCLES - 1)) begin
               drain_cnt_d = '0;
               state_d     = S_RESULT;
            end else begin
               drain_cnt_d = D_W'(drain_cnt_q + D_W'(1));
            end
         end
         S_RESULT: begin
            if (res_ready_i) begin
               done_d  = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Abort overrides everything outside IDLE
      if (abort_i && (state_q != S_IDLE)) begin
         state_d     = S_IDLE;
         beat_cnt_d  = '0;
         drain_cnt_d = '0;
         a_d         = '0;
         b_d         = '0;
         fv_d        = 1'b0;
         done_d      = 1'b0;
      end
   end

endmodule

// File: tb/tb_mac_array_ctrl.sv
// Testbench for mac_array_ctrl: directed jobs with a beat scoreboard.
module tb_mac_array_ctrl;

   localparam int unsigned DW = 16;
   localparam int unsigned M  = 5;
   localparam int unsigned N  = 5;
   localparam int unsigned KW = 8;
   localparam int unsigned D  = 10;
   localparam int unsigned AW = M * DW;
   localparam int unsigned BW = N * DW;

   typedef struct packed {
      logic [AW-1:0] a;
      logic [BW-1:0] b;
   } beat_t;

   logic          clk_i = 1'b0;
   logic          rst_i;
   logic          start_i;
   logic [KW-1:0] k_len_i;
   logic          abort_i;
   logic [AW-1:0] a_data_i;
   logic [BW-1:0] b_data_i;
   logic          op_valid_i;
   logic          op_ready_o;
   logic [AW-1:0] array_a_o;
   logic [BW-1:0] array_b_o;
   logic          feed_a_valid_o;
   logic          feed_b_valid_o;
   logic          a_clr_o;
   logic          b_clr_o;
   logic          acc_clr_o;
   logic          res_valid_o;
   logic          res_ready_i;
   logic          busy_o;
   logic          done_o;

   int    n_vec = 0;
   int    n_err = 0;
   int    cyc   = 0;
   beat_t sb[$];

   mac_array_ctrl #(
      .DATA_WIDTH(DW), .M_ROWS(M), .N_COLS(N), .K_WIDTH(KW), .DRAIN_CYCLES(D)
   ) dut (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .k_len_i(k_len_i),
      .abort_i(abort_i), .a_data_i(a_data_i), .b_data_i(b_data_i),
      .op_valid_i(op_valid_i), .op_ready_o(op_ready_o),
      .array_a_o(array_a_o), .array_b_o(array_b_o),
      .feed_a_valid_o(feed_a_valid_o), .feed_b_valid_o(feed_b_valid_o),
      .a_clr_o(a_clr_o), .b_clr_o(b_clr_o), .acc_clr_o(acc_clr_o),
      .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
      .busy_o(busy_o), .done_o(done_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Advance one edge; outputs are sampled 1 time unit after it
   task automatic tick();
      @(posedge clk_i);
      #1;
      cyc++;
   endtask

   function automatic logic [AW-1:0] rand_a();
      return AW'({$urandom(), $urandom(), $urandom()});
   endfunction

   function automatic logic [BW-1:0] rand_b();
      return BW'({$urandom(), $urandom(), $urandom()});
   endfunction

   task automatic check_idle_outputs(input string tag);
      check_val({tag, "_rdy"},  128'(op_ready_o), 128'(0));
      check_val({tag, "_a"},    128'(array_a_o), 128'(0));
      check_val({tag, "_b"},    128'(array_b_o), 128'(0));
      check_val({tag, "_fv"},   128'({feed_a_valid_o, feed_b_valid_o}), 128'(0));
      check_val({tag, "_clr"},  128'({a_clr_o, b_clr_o, acc_clr_o}), 128'(0));
      check_val({tag, "_res"},  128'(res_valid_o), 128'(0));
      check_val({tag, "_busy"}, 128'(busy_o), 128'(0));
      check_val({tag, "_done"}, 128'(done_o), 128'(0));
   endtask

   // Offer one beat (or a bubble) and check the registered feed one cycle later
   task automatic feed_cycle(input bit offer);
      beat_t exp;
      a_data_i   = rand_a();
      b_data_i   = rand_b();
      op_valid_i = offer;
      if (offer) sb.push_back({a_data_i, b_data_i});
      tick();
      check_val("fv_a", 128'(feed_a_valid_o), 128'(offer));
      check_val("fv_b", 128'(feed_b_valid_o), 128'(offer));
      if (offer) begin
         if (sb.size() == 0) begin
            check_val("sb_empty", 128'(1), 128'(0));
         end else begin
            exp = sb.pop_front();
            check_val("arr_a", 128'(array_a_o), 128'(exp.a));
            check_val("arr_b", 128'(array_b_o), 128'(exp.b));
         end
      end else begin
         check_val("bub_a", 128'(array_a_o), 128'(0));
         check_val("bub_b", 128'(array_b_o), 128'(0));
      end
   endtask

   // Full job; returns in the cycle carrying done_o
   task automatic run_job(input int k, input bit bubbles, input int hold, input bit poke_start);
      int acc;
      int nbub;
      int guard;
      bit offer;
      start_i = 1'b1;
      k_len_i = KW'(k);
      cyc     = 0;
      tick();
      start_i = 1'b0;
      check_val("clr_on", 128'({a_clr_o, b_clr_o, acc_clr_o}), 128'(3'b111));
      check_val("clr_busy", 128'(busy_o), 128'(1));
      check_val("clr_rdy", 128'(op_ready_o), 128'(0));
      tick();
      check_val("clr_off", 128'({a_clr_o, b_clr_o, acc_clr_o}), 128'(0));
      check_val("feed_rdy", 128'(op_ready_o), 128'(1));
      acc   = 0;
      nbub  = 0;
      offer = 1'b1;
      while (acc < k) begin
         if (offer) acc++;
         else nbub++;
         feed_cycle(offer);
         if (bubbles) offer = !offer;
      end
      op_valid_i = 1'b0;
      guard = 0;
      while (!res_valid_o && guard < 600) begin
         tick();
         guard++;
         check_val("drain_fv", 128'(feed_a_valid_o), 128'(0));
         check_val("drain_rdy", 128'(op_ready_o), 128'(0));
      end
      check_val("res_valid", 128'(res_valid_o), 128'(1));
      check_val("res_lat", 128'(cyc), 128'(2 + k + int'(D) + nbub));
      res_ready_i = 1'b0;
      for (int i = 0; i < hold; i++) begin
         if (poke_start && i == 2) begin
            start_i = 1'b1;
            k_len_i = KW'(3);
         end
         tick();
         start_i = 1'b0;
         check_val("bp_res", 128'(res_valid_o), 128'(1));
         check_val("bp_busy", 128'(busy_o), 128'(1));
         check_val("bp_done", 128'(done_o), 128'(0));
      end
      res_ready_i = 1'b1;
      tick();
      res_ready_i = 1'b0;
      check_val("done", 128'(done_o), 128'(1));
      check_val("done_cyc", 128'(cyc), 128'(3 + k + int'(D) + nbub + hold));
      check_val("done_busy", 128'(busy_o), 128'(0));
      check_val("done_res", 128'(res_valid_o), 128'(0));
   endtask

   task automatic idle_after(input string tag);
      tick();
      check_idle_outputs(tag);
   endtask

   initial begin
      rst_i       = 1'b1;
      start_i     = 1'b0;
      k_len_i     = '0;
      abort_i     = 1'b0;
      a_data_i    = '0;
      b_data_i    = '0;
      op_valid_i  = 1'b0;
      res_ready_i = 1'b0;
      repeat (2) @(posedge clk_i);
      #1;
      check_idle_outputs("rst");
      rst_i = 1'b0;
      tick();

      // Basic, bubbles, backpressure with an ignored start
      run_job(5, 1'b0, 0, 1'b0);
      idle_after("basic");
      run_job(4, 1'b1, 0, 1'b0);
      idle_after("bubble");
      run_job(3, 1'b0, 6, 1'b1);
      idle_after("bp");

      // Abort after two of five beats; the offered third beat is refused
      start_i = 1'b1;
      k_len_i = KW'(5);
      tick();
      start_i = 1'b0;
      tick();
      feed_cycle(1'b1);
      feed_cycle(1'b1);
      abort_i    = 1'b1;
      op_valid_i = 1'b1;
      a_data_i   = rand_a();
      b_data_i   = rand_b();
      #1;
      check_val("abort_rdy", 128'(op_ready_o), 128'(0));
      tick();
      abort_i    = 1'b0;
      op_valid_i = 1'b0;
      check_idle_outputs("abort");
      idle_after("abort2");
      run_job(3, 1'b0, 0, 1'b0);
      idle_after("post_abort");

      // Asynchronous reset in the middle of DRAIN
      start_i = 1'b1;
      k_len_i = KW'(3);
      tick();
      start_i    = 1'b0;
      op_valid_i = 1'b1;
      repeat (7) tick();
      op_valid_i = 1'b0;
      check_val("pre_rst_busy", 128'(busy_o), 128'(1));
      #2;
      rst_i = 1'b1;
      #1;
      check_idle_outputs("mid_rst");
      @(negedge clk_i);
      rst_i = 1'b0;
      idle_after("post_rst");

      // k=0 start is ignored
      start_i = 1'b1;
      k_len_i = '0;
      tick();
      start_i = 1'b0;
      check_idle_outputs("k0");
      idle_after("k0b");

      // start together with abort in IDLE
      start_i = 1'b1;
      abort_i = 1'b1;
      k_len_i = KW'(4);
      tick();
      start_i = 1'b0;
      abort_i = 1'b0;
      check_idle_outputs("st_ab");

      // Back-to-back: second start lands in the done cycle
      run_job(2, 1'b0, 0, 1'b0);
      run_job(3, 1'b0, 0, 1'b0);
      idle_after("b2b");

      // Longest job
      run_job(255, 1'b0, 0, 1'b0);
      idle_after("k255");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

endmodule
